// File: rtl/mac_accumulator_pkg.sv
// Shared types and default sizing for the MAC accumulator back-end.
// Optional feature macro handled elsewhere: MAC_SAT_EN (see acc_sat_add).
package mac_acc_pkg;

  localparam int PROD_W_DEF    = 32;
  localparam int ACC_W_DEF     = 40;
  localparam int BURST_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Counter must hold the value BURST_LEN itself, not just BURST_LEN-1.
  function automatic int cnt_w(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / burst-sum-out handshake bundle for mac_accumulator.
// slv = accumulator side, mst = producer/consumer side.
interface mac_accumulator_if
  import mac_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = cnt_w(BURST_LEN_DEF)
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport slv (
    input  in_valid, prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport mst (
    output in_valid, prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/mac_accumulator_acc_sat_add.sv
// Combinational accumulator adder: acc + zero-extended product with carry out.
// With MAC_SAT_EN defined the sum clamps to all-ones on carry.
module acc_sat_add #(
  parameter int ACC_W  = 40,
  parameter int PROD_W = 32
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;
  logic [ACC_W:0] prod_ext;

  assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign full     = {1'b0, acc_i} + prod_ext;
  assign carry_o  = full[ACC_W];

`ifdef MAC_SAT_EN
  // Once clamped, any further nonzero product carries again, so the clamp sticks.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Burst MAC back-end: sums up to BURST_LEN products, presents sum/count/overflow.
// Optional clamp on overflow via MAC_SAT_EN (inside acc_sat_add).
module mac_accumulator
  import mac_acc_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  mac_accumulator_if.slv bus
);

  localparam int CNT_W = cnt_w(BURST_LEN);

  if (ACC_W < PROD_W + 1) begin : g_bad_acc_w
    $error("mac_accumulator: ACC_W must be >= PROD_W+1");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("mac_accumulator: BURST_LEN must be >= 1");
  end

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] sum_d;
  logic             carry;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;
  logic             done_d;
  logic             accept;
  logic             emit;

  assign bus.in_ready  = (state_q != OUT);
  assign accept        = bus.in_valid & bus.in_ready;
  assign emit          = out_valid_q & bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  // IDLE starts a fresh burst: add onto zero so the first product loads directly.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;

  acc_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .acc_i   (acc_base),
    .prod_i  (bus.prod),
    .sum_o   (sum_d),
    .carry_o (carry)
  );

  always_comb begin
    cnt_d  = '0;
    ovf_d  = 1'b0;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = CNT_W'(1);
      ovf_d = carry;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | carry;
    end
    done_d = bus.in_last | (cnt_d == CNT_W'(BURST_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (done_d) begin
              state_q     <= OUT;
              out_valid_q <= 1'b1;
              out_acc_q   <= sum_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= ACC;
            end
          end
        end
        OUT: begin
          if (emit) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
